// File: rtl/data_memory_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage and the debug unit.
// CPU accesses pass through combinationally; debug accesses are acked one cycle after grant.
module data_memory_arbiter #(
    parameter int unsigned NB_DATA        = 32,
    parameter int unsigned NB_ADDR        = 32,
    parameter int unsigned MAX_CPU_STREAK = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_halt,
    input  logic               i_cpu_req,
    input  logic               i_cpu_we,
    input  logic [NB_ADDR-1:0] i_cpu_addr,
    input  logic [NB_DATA-1:0] i_cpu_wdata,
    output logic [NB_DATA-1:0] o_cpu_rdata,
    output logic               o_cpu_stall,
    input  logic               i_dbg_req,
    input  logic               i_dbg_we,
    input  logic [NB_ADDR-1:0] i_dbg_addr,
    input  logic [NB_DATA-1:0] i_dbg_wdata,
    output logic               o_dbg_ack,
    output logic [NB_DATA-1:0] o_dbg_rdata,
    output logic [NB_ADDR-1:0] o_mem_address,
    output logic [NB_DATA-1:0] o_mem_write_data,
    output logic               o_mem_read_enable,
    output logic               o_mem_write_enable,
    output logic               o_mem_valid,
    input  logic [NB_DATA-1:0] i_mem_read_data
);

    localparam logic [7:0] MaxStreak = 8'(MAX_CPU_STREAK);

    logic               ack_pending_q, ack_pending_d;
    logic [7:0]         streak_q, streak_d;
    logic [NB_DATA-1:0] dbg_rdata_q, dbg_rdata_d;

    logic dbg_eligible;
    logic grant_cpu;
    logic grant_dbg;

    // A debug request is not re-eligible during its own ack cycle.
    assign dbg_eligible = i_dbg_req & ~ack_pending_q;

    always_comb begin
        grant_cpu = 1'b0;
        grant_dbg = 1'b0;
        if (i_halt) begin
            grant_dbg = dbg_eligible;
        end else if (dbg_eligible && (streak_q == MaxStreak)) begin
            grant_dbg = 1'b1;
        end else if (i_cpu_req) begin
            grant_cpu = 1'b1;
        end else if (dbg_eligible) begin
            grant_dbg = 1'b1;
        end
    end

    always_comb begin
        o_mem_address      = '0;
        o_mem_write_data   = '0;
        o_mem_read_enable  = 1'b0;
        o_mem_write_enable = 1'b0;
        o_mem_valid        = 1'b0;
        if (grant_cpu) begin
            o_mem_address      = i_cpu_addr;
            o_mem_write_data   = i_cpu_wdata;
            o_mem_read_enable  = ~i_cpu_we;
            o_mem_write_enable = i_cpu_we;
            o_mem_valid        = 1'b1;
        end else if (grant_dbg) begin
            o_mem_address      = i_dbg_addr;
            o_mem_write_data   = i_dbg_wdata;
            o_mem_read_enable  = ~i_dbg_we;
            o_mem_write_enable = i_dbg_we;
            o_mem_valid        = 1'b1;
        end
    end

    assign o_cpu_rdata = (grant_cpu && !i_cpu_we) ? i_mem_read_data : '0;
    assign o_cpu_stall = i_cpu_req & ~i_halt & ~grant_cpu;
    assign o_dbg_ack   = ack_pending_q;
    assign o_dbg_rdata = dbg_rdata_q;

    always_comb begin
        ack_pending_d = grant_dbg;
        dbg_rdata_d   = dbg_rdata_q;
        streak_d      = streak_q;
        if (grant_dbg) begin
            streak_d = '0;
            if (!i_dbg_we) begin
                dbg_rdata_d = i_mem_read_data;
            end
        end else if (!i_dbg_req) begin
            streak_d = '0;
        end else if (grant_cpu && dbg_eligible && (streak_q != MaxStreak)) begin
            // Count only CPU grants that actually made a waiting debug request lose.
            streak_d = streak_q + 8'd1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            ack_pending_q <= 1'b0;
            streak_q      <= '0;
            dbg_rdata_q   <= '0;
        end else begin
            ack_pending_q <= ack_pending_d;
            streak_q      <= streak_d;
            dbg_rdata_q   <= dbg_rdata_d;
        end
    end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Shares the single-port data memory between the CPU MEM stage and the debug unit, which reads and writes memory over UART. CPU accesses pass through combinationally in the same cycle. Debug accesses are granted when the CPU is idle or halted, or forcibly after a bounded CPU streak, and are acknowledged one cycle later with registered read data. The block sits between the MEM stage/debug unit and the data memory's address/data/enable/valid port.

## Interface
- NB_DATA, 32, data width
- NB_ADDR, 32, address width, passed unchanged to memory
- MAX_CPU_STREAK, 8, consecutive CPU grants tolerated while debug waits (1..255)
- i_clock  in  1  single clock, all state on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_halt  in  1  CPU halted; debug has priority, CPU requests are ignored and never granted
- i_cpu_req  in  1  CPU access request (level, per cycle)
- i_cpu_we  in  1  CPU write (1) / read (0)
- i_cpu_addr  in  NB_ADDR  CPU address
- i_cpu_wdata  in  NB_DATA  CPU write data
- o_cpu_rdata  out  NB_DATA  memory read data when CPU is granted on a read, else 0
- o_cpu_stall  out  1  CPU requested but not granted this cycle
- i_dbg_req  in  1  debug access request (level, held until o_dbg_ack)
- i_dbg_we  in  1  debug write / read
- i_dbg_addr  in  NB_ADDR  debug address
- i_dbg_wdata  in  NB_DATA  debug write data
- o_dbg_ack  out  1  one-cycle pulse, cycle after debug grant
- o_dbg_rdata  out  NB_DATA  read data captured at debug grant, held until next debug read
- o_mem_address  out  NB_ADDR  to memory address
- o_mem_write_data  out  NB_DATA  to memory write data
- o_mem_read_enable  out  1  granted access is a read
- o_mem_write_enable  out  1  granted access is a write
- o_mem_valid  out  1  an access is granted this cycle
- i_mem_read_data  in  NB_DATA  combinational memory read data

## Operation
- State: ack_pending (1 bit, registered), streak (8-bit counter), o_dbg_rdata register.
- dbg_eligible = i_dbg_req & ~ack_pending.
- Grant is combinational, evaluated in priority order:
  - i_halt=1: grant debug if dbg_eligible, otherwise none.
  - dbg_eligible & streak==MAX_CPU_STREAK: grant debug.
  - i_cpu_req: grant CPU.
  - dbg_eligible: grant debug.
  - Otherwise none.
- Memory mux:
  - Granted requester's addr, wdata and we drive the memory port.
  - o_mem_valid=1, read_enable=~we, write_enable=we.
  - No grant: all memory outputs are 0.
- o_cpu_stall = i_cpu_req & ~i_halt & ~grant_cpu.
- Debug grant, at the clock edge:
  - ack_pending←1.
  - If a read: o_dbg_rdata←i_mem_read_data.
  - streak←0.
- o_dbg_ack = ack_pending. ack_pending clears the following edge, so each debug access costs at least 2 cycles. A request held high through the ack cycle is a new request and is eligible the next cycle.
- Streak counter:
  - Increments, saturating at MAX_CPU_STREAK, on each CPU grant while i_dbg_req=1 & ~ack_pending.
  - Cleared on debug grant, or on any cycle with i_dbg_req=0.
- A debug write is committed by memory on the grant edge. The ack only confirms it.

## Timing
- Reset (async, i_reset=0): ack_pending=0, streak=0, o_dbg_rdata=0, o_dbg_ack=0. Combinational outputs follow inputs with zero state, so with no requests all outputs are 0.
- CPU latency: 0 cycles. Read data is on o_cpu_rdata in the grant cycle; a write commits at the end of the grant cycle.
- Debug latency: grant in cycle N, o_dbg_ack and o_dbg_rdata valid in N+1. Minimum 2 cycles per debug access.
- Worst-case debug wait with continuous CPU traffic: MAX_CPU_STREAK CPU grants, then 1 debug grant. The CPU stalls exactly that one cycle.
- Simultaneous CPU and debug requests with streak<MAX: CPU wins and debug waits.
- Reset asserted while ack_pending=1: the pending ack is dropped and no ack pulse is issued. If the write was granted before reset, its memory contents persist.
- i_halt rising mid-streak: debug wins the next eligible cycle regardless of streak.
- Address and data are not registered; requesters hold them stable through the grant cycle.

## Test plan
- Reset: drive requests during reset, then release. Required: o_dbg_ack=0, o_dbg_rdata=0, and no memory valid until the first grant.
- CPU only: write 0xDEADBEEF to address 4, then read address 4. Required: o_cpu_rdata=0xDEADBEEF in the read cycle, o_cpu_stall=0 throughout.
- Debug only, idle CPU: read address 4. Required: ack one cycle after the request, o_dbg_rdata=0xDEADBEEF. With the request held, accesses repeat every 2 cycles.
- Starvation guard, MAX_CPU_STREAK=8: CPU requests every cycle, debug requests from cycle 0. Required: 8 CPU grants, then a debug grant with o_cpu_stall=1 for exactly that cycle, then ack, then the streak restarts.
- Halt: i_halt=1 with both requests. Required: the CPU is never granted; debug write 0x12345678 to address 8 then read back returns 0x12345678.
- Reset mid-access: assert reset the cycle after a debug grant. Required: no o_dbg_ack pulse, and all state returns to reset values.
